// File: rtl/imem_loader_if.sv
// Bundle for the imem_loader ports: load request, byte stream, status and fetch.
// The host/core side uses master; the loader uses slave.
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 7
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_cnt;
  logic              abort;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              busy;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] ADDR;
  logic [31:0]       out;

  modport master (
    output start, base_addr, word_cnt, abort, in_valid, in_data, ADDR,
    input  in_ready, busy, cpu_hold, done, err, out
  );

  modport slave (
    input  start, base_addr, word_cnt, abort, in_valid, in_data, ADDR,
    output in_ready, busy, cpu_hold, done, err, out
  );
endinterface

// File: rtl/imem_loader.sv
// Writable instruction RAM filled by a little-endian byte-stream loader,
// with a combinational fetch port reading the same storage.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 7
) (
  input  logic          CLK,
  input  logic          rst_n,
  imem_loader_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SUM_W = ((ADDR_W - 2 > CNT_W) ? ADDR_W - 2 : CNT_W) + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_t;

  state_t             r_state;
  logic [1:0]         r_byte_idx;
  logic [31:0]        r_asm;
  logic [IDX_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_remaining;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  logic [31:0]        r_mem [DEPTH];

  logic [SUM_W-1:0]   w_req_end;
  logic               w_req_bad;
  logic [ADDR_W-3:0]  w_fetch_idx;
  logic               w_fetch_hit;

  // Request is rejected if misaligned, empty, or running past the last word.
  assign w_req_end = SUM_W'(bus.base_addr[ADDR_W-1:2]) + SUM_W'(bus.word_cnt);
  assign w_req_bad = (bus.base_addr[1:0] != 2'b00) || (bus.word_cnt == '0) ||
                     (w_req_end > SUM_W'(DEPTH));

  assign w_fetch_idx = bus.ADDR[ADDR_W-1:2];
  assign w_fetch_hit = SUM_W'(w_fetch_idx) < SUM_W'(DEPTH);
  assign bus.out     = w_fetch_hit ? r_mem[w_fetch_idx[IDX_W-1:0]] : 32'b0;

  assign bus.in_ready = r_in_ready;
  assign bus.busy     = r_busy;
  assign bus.cpu_hold = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_byte_idx  <= 2'd0;
      r_asm       <= 32'b0;
      r_wr_ptr    <= '0;
      r_remaining <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'b0;
      end
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            if (w_req_bad) begin
              r_err <= 1'b1;
            end else begin
              r_state     <= StLoad;
              r_wr_ptr    <= bus.base_addr[IDX_W+1:2];
              r_remaining <= bus.word_cnt;
              r_byte_idx  <= 2'd0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (bus.abort) begin
            r_state    <= StIdle;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b1;
          end else if (bus.in_valid) begin
            r_asm[{r_byte_idx, 3'b000} +: 8] <= bus.in_data;
            r_byte_idx                       <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_state    <= StWrite;
              r_in_ready <= 1'b0;
            end
          end
        end
        StWrite: begin
          // The write completes even when abort arrives in this cycle.
          r_mem[r_wr_ptr] <= r_asm;
          r_wr_ptr        <= r_wr_ptr + IDX_W'(1);
          r_remaining     <= r_remaining - CNT_W'(1);
          if (bus.abort) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else if (r_remaining == CNT_W'(1)) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state    <= StLoad;
            r_in_ready <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized checks of imem_loader against a word-array model
// of the RAM and the expected cycle-by-cycle load protocol.
module tb_imem_loader;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = 7;

  logic CLK   = 1'b0;
  logic rst_n = 1'b0;

  imem_loader_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  logic [31:0] model [DEPTH];
  logic [7:0]  bq [$];
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic busy_e, input logic ready_e,
                            input logic done_e, input logic err_e);
    chk({tag, ".busy"},     {31'b0, bus.busy},     {31'b0, busy_e});
    chk({tag, ".cpu_hold"}, {31'b0, bus.cpu_hold}, {31'b0, busy_e});
    chk({tag, ".in_ready"}, {31'b0, bus.in_ready}, {31'b0, ready_e});
    chk({tag, ".done"},     {31'b0, bus.done},     {31'b0, done_e});
    chk({tag, ".err"},      {31'b0, bus.err},      {31'b0, err_e});
  endtask

  task automatic fetch_sweep(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      bus.ADDR = ADDR_W'(i * 4 + int'($urandom_range(0, 3)));
      #1;
      chk(tag, bus.out, model[i]);
    end
    @(negedge CLK);
  endtask

  task automatic reject(input logic [7:0] base, input int cnt);
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.word_cnt  = CNT_W'(cnt);
    @(negedge CLK);
    bus.start = 1'b0;
    chk_status("reject", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    chk_status("post_reject", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // kill_at: number of accepted bytes before abort/reset (-1 = run to completion).
  task automatic load(input logic [7:0] base, input int cnt, input int gap,
                      input int kill_at, input bit kill_rst, input bit noise);
    int          nbytes = 0;
    int          ptr    = int'(base[ADDR_W-1:2]);
    logic [31:0] w;
    bus.start     = 1'b1;
    bus.base_addr = base;
    bus.word_cnt  = CNT_W'(cnt);
    bus.ADDR      = base;
    @(negedge CLK);
    bus.start = 1'b0;
    for (int wd = 0; wd < cnt; wd++) begin
      w = 32'b0;
      for (int b = 0; b < 4; b++) begin
        for (int g = 0; g < gap; g++) begin
          bus.in_valid = 1'b0;
          bus.start    = 1'b0;
          chk_status("gap", 1'b1, 1'b1, 1'b0, 1'b0);
          @(negedge CLK);
        end
        if (nbytes == kill_at) begin
          bus.in_valid = 1'b0;
          bus.start    = 1'b0;
          if (kill_rst) begin
            #2 rst_n = 1'b0;
            #1;
            for (int i = 0; i < DEPTH; i++) model[i] = 32'b0;
            chk_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
            chk("rst.fetch", bus.out, 32'b0);
            @(negedge CLK);
            rst_n = 1'b1;
            @(negedge CLK);
            chk_status("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
          end else begin
            bus.abort = 1'b1;
            @(negedge CLK);
            bus.abort = 1'b0;
            chk_status("abort", 1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge CLK);
            chk_status("post_abort", 1'b0, 1'b0, 1'b0, 1'b0);
          end
          return;
        end
        bus.in_valid  = 1'b1;
        bus.in_data   = (bq.size() != 0) ? bq.pop_front() : 8'($urandom);
        w[8*b +: 8]   = bus.in_data;
        bus.start     = noise;
        bus.base_addr = 8'h00;
        bus.word_cnt  = CNT_W'(1);
        chk_status("beat", 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        nbytes++;
      end
      // Write cycle: a byte offered here must not be taken.
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      chk_status("write", 1'b1, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
      bus.in_valid = 1'b0;
      model[ptr + wd] = w;
    end
    chk_status("done", 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge CLK);
    chk_status("post_done", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_prog();
    bq = '{8'h93, 8'h01, 8'hF0, 8'h00, 8'h13, 8'h02, 8'h70, 8'h00};
  endtask

  task automatic chk_prog(input string tag);
    bus.ADDR = 8'h04;
    #1 chk({tag, ".w0"}, bus.out, 32'h00F00193);
    bus.ADDR = 8'h0B;
    #1 chk({tag, ".w1"}, bus.out, 32'h00700213);
    @(negedge CLK);
  endtask

  int rb;
  int rc;
  int rg;
  int rk;

  initial begin
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.word_cnt  = '0;
    bus.abort     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.ADDR      = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'b0;

    repeat (2) @(negedge CLK);
    chk_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge CLK);
    fetch_sweep("t1.fetch");

    push_prog();
    load(8'h04, 2, 0, -1, 1'b0, 1'b0);
    chk_prog("t2");

    push_prog();
    load(8'h04, 2, 1, -1, 1'b0, 1'b1);
    chk_prog("t3");

    reject(8'h06, 1);
    reject(8'hF8, 3);
    reject(8'h00, 0);
    reject(8'h00, 65);
    load(8'hFC, 1, 0, -1, 1'b0, 1'b0);

    load(8'h20, 3, 0, 6, 1'b0, 1'b0);
    bus.ADDR = 8'h24;
    #1 chk("t5.word2", bus.out, 32'b0);
    @(negedge CLK);
    load(8'h40, 1, 0, -1, 1'b0, 1'b0);

    load(8'h30, 2, 0, 5, 1'b1, 1'b1);
    fetch_sweep("t6.fetch");

    repeat (8) begin
      rb = int'($urandom_range(0, 60));
      rc = int'($urandom_range(1, (64 - rb) > 6 ? 6 : (64 - rb)));
      rg = int'($urandom_range(0, 2));
      rk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4 * rc - 1)) : -1;
      load(8'(rb * 4), rc, rg, rk, 1'b0, 1'b1);
    end
    fetch_sweep("rand.fetch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
